dbus_xbar: RTL and testbench

Parametrised data-bus crossbar between NCORES CPU data ports and NSLAVES memory-mapped targets (dmem, vmem, perf, hart-info, …).
- Decodes each core address against per-slave base/mask windows.
- Arbitrates each slave round-robin among requesting cores, stalling the losers.
- Routes synchronous-read data back with a registered return path.
- Replaces the fixed bit-decode and per-target stall OR-ing with one generic block that adds unmapped-address error reporting and slave back-pressure.

---
 rtl/dbus_xbar.sv | 171 +++++++++++++++++
 tb/tb_dbus_xbar.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_xbar.sv
// Data-bus crossbar: address-window decode, per-slave round-robin arbitration,
// one-cycle read return with unmapped-address error reporting.
module dbus_xbar #(
    parameter int unsigned NCORES     = 4,
    parameter int unsigned NSLAVES    = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [NSLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
        {32'h10000000, 32'h20000000, 32'h40001000, 32'h40000000},
    parameter logic [NSLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
        {32'hF0000000, 32'hF0000000, 32'hFFFFF000, 32'hFFFFF000}
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NCORES-1:0]              m_req_i,
    input  logic [NCORES-1:0]              m_we_i,
    input  logic [NCORES*ADDR_WIDTH-1:0]   m_addr_i,
    input  logic [NCORES*DATA_WIDTH-1:0]   m_wdata_i,
    input  logic [NCORES*STRB_WIDTH-1:0]   m_wstrb_i,
    output logic [NCORES-1:0]              m_stall_o,
    output logic [NCORES-1:0]              m_rvalid_o,
    output logic [NCORES*DATA_WIDTH-1:0]   m_rdata_o,
    output logic [NCORES-1:0]              m_err_o,
    output logic [NSLAVES-1:0]             s_req_o,
    output logic [NSLAVES-1:0]             s_we_o,
    output logic [NSLAVES*ADDR_WIDTH-1:0]  s_addr_o,
    output logic [NSLAVES*DATA_WIDTH-1:0]  s_wdata_o,
    output logic [NSLAVES*STRB_WIDTH-1:0]  s_wstrb_o,
    input  logic [NSLAVES-1:0]             s_ready_i,
    input  logic [NSLAVES*DATA_WIDTH-1:0]  s_rdata_i
);

    localparam int unsigned PW = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int unsigned SW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

    logic [NCORES-1:0]     hit;
    logic [SW-1:0]         sel     [NCORES];
    logic [PW-1:0]         rr_ptr  [NSLAVES];
    logic [PW-1:0]         s_win   [NSLAVES];
    logic [NSLAVES-1:0]    s_gnt;
    logic [NCORES-1:0]     m_gnt;
    logic [NCORES-1:0]     rd_pend;
    logic [NCORES-1:0]     rd_unm;
    logic [NCORES-1:0]     err_q;
    logic [SW-1:0]         rd_sel  [NCORES];
    logic [DATA_WIDTH-1:0] rd_mux  [NCORES];
    logic [DATA_WIDTH-1:0] rdata_q [NCORES];

    // Lowest-indexed matching window wins.
    always_comb begin
        for (int unsigned c = 0; c < NCORES; c++) begin
            hit[c] = 1'b0;
            sel[c] = '0;
            for (int unsigned s = 0; s < NSLAVES; s++) begin
                if (!hit[c] &&
                    ((m_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH] & SLAVE_MASK[s*ADDR_WIDTH +: ADDR_WIDTH]) ==
                     (SLAVE_BASE[s*ADDR_WIDTH +: ADDR_WIDTH] & SLAVE_MASK[s*ADDR_WIDTH +: ADDR_WIDTH]))) begin
                    hit[c] = 1'b1;
                    sel[c] = SW'(s);
                end
            end
        end
    end

    // Round-robin as minimum circular distance from rr_ptr, avoiding computed indices.
    always_comb begin : arb
        int unsigned rr;
        int unsigned d;
        int unsigned best;
        for (int unsigned s = 0; s < NSLAVES; s++) begin
            rr       = 32'(rr_ptr[s]);
            best     = NCORES;
            d        = 0;
            s_win[s] = '0;
            for (int unsigned c = 0; c < NCORES; c++) begin
                if (m_req_i[c] && hit[c] && (sel[c] == SW'(s))) begin
                    d = (c >= rr) ? (c - rr) : (c + NCORES - rr);
                    if (d < best) begin
                        best     = d;
                        s_win[s] = PW'(c);
                    end
                end
            end
            s_gnt[s] = (best < NCORES) && s_ready_i[s];
        end
    end

    always_comb begin
        m_gnt = '0;
        for (int unsigned c = 0; c < NCORES; c++) begin
            for (int unsigned s = 0; s < NSLAVES; s++) begin
                if (s_gnt[s] && (s_win[s] == PW'(c))) begin
                    m_gnt[c] = 1'b1;
                end
            end
        end
    end

    assign m_stall_o = m_req_i & hit & ~m_gnt;

    always_comb begin
        s_req_o   = '0;
        s_we_o    = '0;
        s_addr_o  = '0;
        s_wdata_o = '0;
        s_wstrb_o = '0;
        for (int unsigned s = 0; s < NSLAVES; s++) begin
            if (s_gnt[s] && rst_ni) begin
                s_req_o[s] = 1'b1;
                for (int unsigned c = 0; c < NCORES; c++) begin
                    if (s_win[s] == PW'(c)) begin
                        s_we_o[s]                             = m_we_i[c];
                        s_addr_o[s*ADDR_WIDTH +: ADDR_WIDTH]  = m_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH];
                        s_wdata_o[s*DATA_WIDTH +: DATA_WIDTH] = m_wdata_i[c*DATA_WIDTH +: DATA_WIDTH];
                        s_wstrb_o[s*STRB_WIDTH +: STRB_WIDTH] = m_wstrb_i[c*STRB_WIDTH +: STRB_WIDTH];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned s = 0; s < NSLAVES; s++) begin
                rr_ptr[s] <= '0;
            end
            for (int unsigned c = 0; c < NCORES; c++) begin
                rd_sel[c]  <= '0;
                rdata_q[c] <= '0;
            end
            rd_pend <= '0;
            rd_unm  <= '0;
            err_q   <= '0;
        end else begin
            for (int unsigned s = 0; s < NSLAVES; s++) begin
                if (s_gnt[s]) begin
                    rr_ptr[s] <= (32'(s_win[s]) == NCORES - 1) ? '0 : PW'(32'(s_win[s]) + 1);
                end
            end
            for (int unsigned c = 0; c < NCORES; c++) begin
                rd_pend[c] <= m_req_i[c] & ~m_we_i[c] & (m_gnt[c] | ~hit[c]);
                rd_unm[c]  <= ~hit[c];
                rd_sel[c]  <= sel[c];
                err_q[c]   <= m_req_i[c] & ~hit[c];
                if (rd_pend[c]) begin
                    rdata_q[c] <= rd_mux[c];
                end
            end
        end
    end

    // Returned data is muxed live from the slave; rdata_q only holds it afterwards.
    always_comb begin
        for (int unsigned c = 0; c < NCORES; c++) begin
            rd_mux[c] = '0;
            if (!rd_unm[c]) begin
                for (int unsigned s = 0; s < NSLAVES; s++) begin
                    if (rd_sel[c] == SW'(s)) begin
                        rd_mux[c] = s_rdata_i[s*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
            m_rdata_o[c*DATA_WIDTH +: DATA_WIDTH] = rd_pend[c] ? rd_mux[c] : rdata_q[c];
        end
    end

    assign m_rvalid_o = rd_pend;
    assign m_err_o    = err_q;

endmodule

// File: tb/tb_dbus_xbar.sv
// Self-checking bench for dbus_xbar: directed scenarios followed by random
// traffic, all compared against a behavioural crossbar model.
module tb_dbus_xbar;

    localparam int NC = 4;
    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SB = 4;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic [NC-1:0]     m_req_i = '0;
    logic [NC-1:0]     m_we_i = '0;
    logic [NC*AW-1:0]  m_addr_i = '0;
    logic [NC*DW-1:0]  m_wdata_i = '0;
    logic [NC*SB-1:0]  m_wstrb_i = '0;
    logic [NC-1:0]     m_stall_o;
    logic [NC-1:0]     m_rvalid_o;
    logic [NC*DW-1:0]  m_rdata_o;
    logic [NC-1:0]     m_err_o;
    logic [NS-1:0]     s_req_o;
    logic [NS-1:0]     s_we_o;
    logic [NS*AW-1:0]  s_addr_o;
    logic [NS*DW-1:0]  s_wdata_o;
    logic [NS*SB-1:0]  s_wstrb_o;
    logic [NS-1:0]     s_ready_i = '1;
    logic [NS*DW-1:0]  s_rdata_i = '0;

    dbus_xbar #(
        .NCORES    (NC),
        .NSLAVES   (NS),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .STRB_WIDTH(SB)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .m_req_i   (m_req_i),
        .m_we_i    (m_we_i),
        .m_addr_i  (m_addr_i),
        .m_wdata_i (m_wdata_i),
        .m_wstrb_i (m_wstrb_i),
        .m_stall_o (m_stall_o),
        .m_rvalid_o(m_rvalid_o),
        .m_rdata_o (m_rdata_o),
        .m_err_o   (m_err_o),
        .s_req_o   (s_req_o),
        .s_we_o    (s_we_o),
        .s_addr_o  (s_addr_o),
        .s_wdata_o (s_wdata_o),
        .s_wstrb_o (s_wstrb_o),
        .s_ready_i (s_ready_i),
        .s_rdata_i (s_rdata_i)
    );

    always #5 clk = ~clk;

    // Memory map in slave order: vmem, hart-info, perf, dmem.
    bit [31:0] base_tab [NS] = '{32'h40000000, 32'h40001000, 32'h20000000, 32'h10000000};
    bit [31:0] mask_tab [NS] = '{32'hFFFFF000, 32'hFFFFF000, 32'hF0000000, 32'hF0000000};

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    int          ptr      [NS];
    bit          pend_rd  [NC];
    bit          pend_unm [NC];
    bit          pend_err [NC];
    int          pend_sl  [NC];
    logic [DW-1:0] last_rd [NC];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int s = 0; s < NS; s++)
            if ((a & mask_tab[s]) == (base_tab[s] & mask_tab[s])) return s;
        return -1;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0:       return 32'h40000000 | (r & 32'h00000FFC);
            1:       return 32'h40001000 | (r & 32'h00000FFC);
            2:       return 32'h20000000 | (r & 32'h0FFFFFFC);
            3, 4:    return 32'h10000000 | (r & 32'h000000FC);
            default: return r[0] ? (32'h40002000 | (r & 32'h00000FFC))
                                 : (32'h80000000 | (r & 32'h7FFFFFFC));
        endcase
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NS; s++) ptr[s] = 0;
        for (int c = 0; c < NC; c++) begin
            pend_rd[c] = 0; pend_unm[c] = 0; pend_err[c] = 0; pend_sl[c] = 0;
            last_rd[c] = '0;
        end
    endtask

    // Compare every DUT output with the model at the falling edge, then advance the model.
    task automatic sample();
        logic [NS-1:0]    e_req, e_we;
        logic [NS*AW-1:0] e_addr;
        logic [NS*DW-1:0] e_wdata;
        logic [NS*SB-1:0] e_wstrb;
        logic [NC-1:0]    e_stall, e_rv, e_err, gnt;
        logic [NC*DW-1:0] e_rdata;
        int               dec [NC];
        int               win, k;
        @(negedge clk);
        if (!rst_ni) begin
            check("rst_s_req",  128'(s_req_o),    '0);
            check("rst_rvalid", 128'(m_rvalid_o), '0);
            check("rst_err",    128'(m_err_o),    '0);
            check("rst_rdata",  128'(m_rdata_o),  '0);
            model_reset();
            return;
        end
        for (int c = 0; c < NC; c++) dec[c] = decode(m_addr_i[c*AW +: AW]);
        e_req = '0; e_we = '0; e_addr = '0; e_wdata = '0; e_wstrb = '0; gnt = '0;
        for (int s = 0; s < NS; s++) begin
            win = -1;
            for (int i = 0; i < NC; i++) begin
                k = (ptr[s] + i) % NC;
                if (win < 0 && m_req_i[k] && dec[k] == s) win = k;
            end
            if (win >= 0 && s_ready_i[s]) begin
                gnt[win]             = 1'b1;
                e_req[s]             = 1'b1;
                e_we[s]              = m_we_i[win];
                e_addr[s*AW +: AW]   = m_addr_i[win*AW +: AW];
                e_wdata[s*DW +: DW]  = m_wdata_i[win*DW +: DW];
                e_wstrb[s*SB +: SB]  = m_wstrb_i[win*SB +: SB];
                ptr[s]               = (win + 1) % NC;
            end
        end
        for (int c = 0; c < NC; c++) begin
            e_stall[c] = m_req_i[c] && dec[c] >= 0 && !gnt[c];
            e_rv[c]    = pend_rd[c];
            e_err[c]   = pend_err[c];
            e_rdata[c*DW +: DW] = pend_rd[c] ? (pend_unm[c] ? '0 : s_rdata_i[pend_sl[c]*DW +: DW])
                                             : last_rd[c];
        end
        check("s_req",   128'(s_req_o),    128'(e_req));
        check("s_we",    128'(s_we_o),     128'(e_we));
        check("s_addr",  128'(s_addr_o),   128'(e_addr));
        check("s_wdata", 128'(s_wdata_o),  128'(e_wdata));
        check("s_wstrb", 128'(s_wstrb_o),  128'(e_wstrb));
        check("m_stall", 128'(m_stall_o),  128'(e_stall));
        check("m_rvalid",128'(m_rvalid_o), 128'(e_rv));
        check("m_err",   128'(m_err_o),    128'(e_err));
        check("m_rdata", 128'(m_rdata_o),  128'(e_rdata));
        for (int c = 0; c < NC; c++) begin
            last_rd[c]  = e_rdata[c*DW +: DW];
            pend_rd[c]  = m_req_i[c] && !m_we_i[c] && (gnt[c] || dec[c] < 0);
            pend_unm[c] = dec[c] < 0;
            pend_sl[c]  = dec[c];
            pend_err[c] = m_req_i[c] && dec[c] < 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        sample();
        tick();
        rst_ni = 1'b1;
    endtask

    initial begin
        logic [1:0] exp2;
        model_reset();
        sample();
        tick();
        sample();
        tick();
        rst_ni = 1'b1;

        // Single read of dmem, one-cycle return.
        m_req_i = 4'b0001; m_we_i = '0;
        m_addr_i[0*AW +: AW] = 32'h10000010;
        s_rdata_i[3*DW +: DW] = 32'hCAFEF00D;
        sample();
        check("t1_req",   128'(s_req_o), 128'(4'b1000));
        check("t1_addr",  128'(s_addr_o[3*AW +: AW]), 128'(32'h10000010));
        check("t1_stall", 128'(m_stall_o), '0);
        tick();
        m_req_i = '0;
        sample();
        check("t1_rvalid", 128'(m_rvalid_o[0]), 128'(1'b1));
        check("t1_rdata",  128'(m_rdata_o[0*DW +: DW]), 128'(32'hCAFEF00D));
        tick();

        // Two cores contending for dmem from reset alternate 0,1,0,1.
        do_reset();
        m_req_i = 4'b0011; m_we_i = '0;
        m_addr_i[0*AW +: AW] = 32'h10000000;
        m_addr_i[1*AW +: AW] = 32'h10000100;
        for (int n = 0; n < 4; n++) begin
            sample();
            exp2 = (n % 2 == 0) ? 2'b10 : 2'b01;
            check("t2_stall", 128'(m_stall_o[1:0]), 128'(exp2));
            check("t2_req",   128'(s_req_o), 128'(4'b1000));
            tick();
        end
        m_req_i = '0;
        sample();
        tick();

        // Concurrent write to perf and read of hart-info.
        m_req_i = 4'b0011; m_we_i = 4'b0001;
        m_addr_i[0*AW +: AW] = 32'h20000004;
        m_wstrb_i[0*SB +: SB] = 4'b0011;
        m_wdata_i[0*DW +: DW] = 32'h11223344;
        m_addr_i[1*AW +: AW] = 32'h40001000;
        s_rdata_i[1*DW +: DW] = 32'h48415254;
        sample();
        check("t3_req",   128'(s_req_o), 128'(4'b0110));
        check("t3_stall", 128'(m_stall_o), '0);
        check("t3_wstrb", 128'(s_wstrb_o[2*SB +: SB]), 128'(4'b0011));
        tick();
        m_req_i = '0; m_we_i = '0;
        sample();
        check("t3_rvalid", 128'(m_rvalid_o), 128'(4'b0010));
        check("t3_rdata",  128'(m_rdata_o[1*DW +: DW]), 128'(32'h48415254));
        tick();

        // Unmapped read.
        m_req_i = 4'b0100;
        m_addr_i[2*AW +: AW] = 32'h80000000;
        sample();
        check("t4_req",   128'(s_req_o), '0);
        check("t4_stall", 128'(m_stall_o), '0);
        tick();
        m_req_i = '0;
        sample();
        check("t4_err",    128'(m_err_o), 128'(4'b0100));
        check("t4_rvalid", 128'(m_rvalid_o), 128'(4'b0100));
        check("t4_rdata",  128'(m_rdata_o[2*DW +: DW]), '0);
        tick();

        // Back-pressure on dmem for three cycles.
        m_req_i = 4'b0001;
        m_addr_i[0*AW +: AW] = 32'h10000020;
        s_ready_i = 4'b0111;
        for (int n = 0; n < 3; n++) begin
            sample();
            check("t5_stall", 128'(m_stall_o[0]), 128'(1'b1));
            check("t5_noreq", 128'(s_req_o[3]), '0);
            tick();
        end
        s_ready_i = '1;
        sample();
        check("t5_req",   128'(s_req_o[3]), 128'(1'b1));
        check("t5_go",    128'(m_stall_o[0]), '0);
        tick();
        m_req_i = '0;
        s_rdata_i[3*DW +: DW] = 32'h5A5A0003;
        sample();
        check("t5_rvalid", 128'(m_rvalid_o[0]), 128'(1'b1));
        check("t5_rdata",  128'(m_rdata_o[0*DW +: DW]), 128'(32'h5A5A0003));
        tick();

        // Reset right after a granted read drops the return.
        m_req_i = 4'b0001;
        m_addr_i[0*AW +: AW] = 32'h10000040;
        sample();
        tick();
        rst_ni = 1'b0;
        m_req_i = '0;
        sample();
        check("t6_rst_rvalid", 128'(m_rvalid_o), '0);
        tick();
        rst_ni = 1'b1;
        sample();
        check("t6_post_rvalid", 128'(m_rvalid_o), '0);
        tick();
        m_req_i = 4'b1111; m_we_i = '0;
        for (int c = 0; c < NC; c++) m_addr_i[c*AW +: AW] = 32'h10000000 + 32'(c * 16);
        sample();
        check("t6_stall", 128'(m_stall_o), 128'(4'b1110));
        check("t6_addr",  128'(s_addr_o[3*AW +: AW]), 128'(32'h10000000));
        tick();
        m_req_i = '0;
        sample();
        tick();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            rst_ni    = ($urandom_range(0, 149) != 0);
            m_req_i   = 4'($urandom);
            m_we_i    = 4'($urandom);
            for (int c = 0; c < NC; c++) begin
                m_addr_i[c*AW +: AW]  = rand_addr();
                m_wdata_i[c*DW +: DW] = $urandom;
                m_wstrb_i[c*SB +: SB] = 4'($urandom);
            end
            for (int s = 0; s < NS; s++) begin
                s_ready_i[s]          = ($urandom_range(0, 3) != 0);
                s_rdata_i[s*DW +: DW] = $urandom;
            end
            sample();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
